// File: rtl/tl_burst_arbiter_d.sv
// Round-robin N-to-1 TileLink D-channel arbiter that locks the grant for multi-beat bursts.
// Define TL_ARB_D_OUT_REG_EN to insert a 2-entry registered skid buffer after the mux.

package tl_arb_d_pkg;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [7:0]  source;
    logic [63:0] data;
  } tl_d_chan_t;
endpackage

module tl_burst_arbiter_d #(
  parameter int  SLAVE_NUM  = 2,
  parameter type DATA_T     = tl_arb_d_pkg::tl_d_chan_t,
  parameter int  BEAT_BYTES = 8,
  parameter int  MAX_SIZE   = 6,
  localparam int SEL_W      = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  DATA_T                inp_bits_i [SLAVE_NUM-1:0],
  input  logic [SLAVE_NUM-1:0] inp_valid_i,
  output logic [SLAVE_NUM-1:0] inp_ready_o,
  output DATA_T                oup_bits_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i,
  output logic [SEL_W-1:0]     oup_sel_o,
  output logic                 oup_last_o
);

  localparam int MAX_BEATS  = (2 ** MAX_SIZE) / BEAT_BYTES;
  localparam int CNT_W      = $clog2(MAX_BEATS) + 1;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_e;

  state_e           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic [CNT_W-1:0] beat_cnt;

  logic [SEL_W-1:0] winner;
  logic             any_valid;
  logic [SEL_W-1:0] sel;
  DATA_T            mux_bits;
  logic             mux_valid;
  logic             mux_last;
  logic             mux_ready;
  logic [CNT_W-1:0] beats;
  logic             hs;

  // Only data-carrying opcodes (AccessAckData, GrantData) span more than one beat.
  function automatic logic [CNT_W-1:0] msg_beats(input logic [2:0] opcode, input int size);
    int n;
    n = 1;
    if (opcode == 3'd1 || opcode == 3'd5) begin
      if (size > MAX_SIZE)        n = MAX_BEATS;
      else if (size > BEAT_SHIFT) n = 1 << (size - BEAT_SHIFT);
    end
    return CNT_W'(n);
  endfunction

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return (int'(idx) == SLAVE_NUM - 1) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    winner    = rr_ptr;
    any_valid = 1'b0;
    for (int k = 0; k < SLAVE_NUM; k++) begin
      logic [SEL_W-1:0] idx;
      idx = SEL_W'((int'(rr_ptr) + k) % SLAVE_NUM);
      if (!any_valid && inp_valid_i[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  // Once a message is presented (HOLD) or a burst is running, only the granted input is visible.
  always_comb begin
    sel       = (state == IDLE) ? winner : grant;
    mux_valid = (state == IDLE) ? any_valid : inp_valid_i[sel];
    if (rst_i) begin
      sel       = '0;
      mux_valid = 1'b0;
    end
    mux_bits = inp_bits_i[sel];
    beats    = msg_beats(mux_bits.opcode, int'(mux_bits.size));
    mux_last = 1'b0;
    if (!rst_i) mux_last = (state == BURST) ? (beat_cnt == CNT_W'(1)) : (beats == CNT_W'(1));
  end

  assign hs = mux_valid & mux_ready;

  always_comb begin
    inp_ready_o      = '0;
    inp_ready_o[sel] = mux_ready & mux_valid;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (hs) begin
            if (beats == CNT_W'(1)) begin
              rr_ptr <= next_idx(sel);
              state  <= IDLE;
            end else begin
              beat_cnt <= beats - 1'b1;
              grant    <= sel;
              state    <= BURST;
            end
          end else if (mux_valid) begin
            grant <= sel;
            state <= HOLD;
          end
        end
        BURST: begin
          if (hs) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == CNT_W'(1)) begin
              rr_ptr <= next_idx(grant);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TL_ARB_D_OUT_REG_EN
  DATA_T            buf_bits [2];
  logic             buf_last [2];
  logic [SEL_W-1:0] buf_sel  [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             pop;

  // Ready depends only on occupancy, which breaks the oup_ready_i -> inp_ready_o path.
  assign mux_ready = (count != 2'd2);
  assign pop       = oup_valid_o & oup_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (hs)  wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(hs) - 2'(pop);
    end
  end

  // NOTE: buffer storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      buf_bits[wr_ptr] <= mux_bits;
      buf_last[wr_ptr] <= mux_last;
      buf_sel[wr_ptr]  <= sel;
    end
  end

  assign oup_valid_o = (count != 2'd0);
  assign oup_bits_o  = buf_bits[rd_ptr];
  assign oup_last_o  = oup_valid_o & buf_last[rd_ptr];
  assign oup_sel_o   = oup_valid_o ? buf_sel[rd_ptr] : '0;
`else
  assign mux_ready   = oup_ready_i;
  assign oup_valid_o = mux_valid;
  assign oup_bits_o  = mux_bits;
  assign oup_last_o  = mux_last;
  assign oup_sel_o   = sel;
`endif

endmodule

// File: tb/tb_tl_burst_arbiter_d.sv
// Directed bench for tl_burst_arbiter_d (3 inputs, 8-byte beats, MAX_SIZE=6) in its default build.

module tb_tl_burst_arbiter_d;
  import tl_arb_d_pkg::*;

  localparam logic [2:0] OP_ACK        = 3'd0;
  localparam logic [2:0] OP_ACK_DATA   = 3'd1;
  localparam logic [2:0] OP_GRANT_DATA = 3'd5;

  logic       clk_i = 1'b0;
  logic       rst_i;
  tl_d_chan_t inp_bits [2:0];
  logic [2:0] inp_valid;
  logic [2:0] inp_ready;
  tl_d_chan_t oup_bits;
  logic       oup_valid;
  logic       oup_ready;
  logic [1:0] oup_sel;
  logic       oup_last;

  int n_checks = 0;
  int n_fail   = 0;

  tl_burst_arbiter_d #(
    .SLAVE_NUM (3),
    .DATA_T    (tl_d_chan_t),
    .BEAT_BYTES(8),
    .MAX_SIZE  (6)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inp_bits_i (inp_bits),
    .inp_valid_i(inp_valid),
    .inp_ready_o(inp_ready),
    .oup_bits_o (oup_bits),
    .oup_valid_o(oup_valid),
    .oup_ready_i(oup_ready),
    .oup_sel_o  (oup_sel),
    .oup_last_o (oup_last)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] i, input logic v, input logic [2:0] op,
                       input logic [3:0] sz, input logic [63:0] d);
    tl_d_chan_t p;
    p.opcode = op;
    p.param  = 2'd0;
    p.size   = sz;
    p.source = {6'd0, i};
    p.data   = d;
    inp_bits[i]  = p;
    inp_valid[i] = v;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) drive(2'(k), 1'b0, OP_ACK, 4'd3, 64'd0);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int beat;
    rst_i     = 1'b1;
    oup_ready = 1'b1;
    for (int k = 0; k < 3; k++) drive(2'(k), 1'b1, OP_ACK, 4'd3, 64'(k + 100));
    tick();

    // Reset with all inputs valid: nothing offered, nothing accepted.
    repeat (2) begin
      #1;
      check("rst_valid", 64'(oup_valid), 64'd0);
      check("rst_ready", 64'(inp_ready), 64'd0);
      check("rst_sel",   64'(oup_sel),   64'd0);
      check("rst_last",  64'(oup_last),  64'd0);
      tick();
    end
    rst_i = 1'b0;

    // Round-robin over single-beat AccessAcks: 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_valid",  64'(oup_valid),       64'd1);
      check("rr_sel",    64'(oup_sel),         64'(k % 3));
      check("rr_source", 64'(oup_bits.source), 64'(k % 3));
      check("rr_ready",  64'(inp_ready),       64'(1 << (k % 3)));
      check("rr_last",   64'(oup_last),        64'd1);
      tick();
    end

    // Burst lock: 8-beat AccessAckData on input 0, input 1 waiting from beat 2 on.
    idle_all();
    drive(2'd0, 1'b1, OP_ACK_DATA, 4'd6, 64'd1);
    #1;
    check("lock_b1_sel",   64'(oup_sel),   64'd0);
    check("lock_b1_ready", 64'(inp_ready), 64'b001);
    check("lock_b1_last",  64'(oup_last),  64'd0);
    tick();
    drive(2'd1, 1'b1, OP_ACK, 4'd3, 64'h55);
    for (int b = 2; b <= 8; b++) begin
      drive(2'd0, 1'b1, OP_ACK_DATA, 4'd6, 64'(b));
      #1;
      check("lock_ready", 64'(inp_ready),     64'b001);
      check("lock_data",  oup_bits.data,      64'(b));
      check("lock_last",  64'(oup_last),      64'(b == 8));
      tick();
    end
    drive(2'd0, 1'b0, OP_ACK, 4'd3, 64'd0);
    #1;
    check("lock_after_sel",   64'(oup_sel),   64'd1);
    check("lock_after_ready", 64'(inp_ready), 64'b010);
    tick();

    // Single beat from input 2 brings rr_ptr back to 0.
    idle_all();
    drive(2'd2, 1'b1, OP_ACK, 4'd3, 64'h22);
    #1;
    check("wrap_sel", 64'(oup_sel), 64'd2);
    tick();

    // Backpressure: input 1 held, then input 0 arrives while rr_ptr=0.
    idle_all();
    oup_ready = 1'b0;
    drive(2'd1, 1'b1, OP_ACK, 4'd3, 64'hA5A5);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_sel",   64'(oup_sel),   64'd1);
      check("hold_valid", 64'(oup_valid), 64'd1);
      check("hold_ready", 64'(inp_ready), 64'b000);
      tick();
    end
    drive(2'd0, 1'b1, OP_ACK, 4'd3, 64'hBEEF);
    #1;
    check("hold_mask_sel",  64'(oup_sel),  64'd1);
    check("hold_mask_data", oup_bits.data, 64'hA5A5);
    tick();
    oup_ready = 1'b1;
    #1;
    check("hold_hs_sel",   64'(oup_sel),   64'd1);
    check("hold_hs_ready", 64'(inp_ready), 64'b010);
    check("hold_hs_data",  oup_bits.data,  64'hA5A5);
    tick();
    drive(2'd1, 1'b0, OP_ACK, 4'd3, 64'd0);
    #1;
    check("hold_next_sel", 64'(oup_sel),   64'd0);
    check("hold_next_rdy", 64'(inp_ready), 64'b001);
    tick();

    // GrantData size 9 saturates at 8 beats; valid gaps on cycles 3 and 4.
    idle_all();
    drive(2'd2, 1'b1, OP_ACK, 4'd3, 64'h77);
    beat = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      logic v;
      v = !(cyc == 3 || cyc == 4);
      drive(2'd1, v, OP_GRANT_DATA, 4'd9, 64'(cyc));
      #1;
      check("gap_sel", 64'(oup_sel), 64'd1);
      if (v) begin
        beat++;
        check("gap_ready", 64'(inp_ready), 64'b010);
        check("gap_last",  64'(oup_last),  64'(beat == 8));
      end else begin
        check("gap_valid",      64'(oup_valid), 64'd0);
        check("gap_mask_ready", 64'(inp_ready), 64'b000);
      end
      tick();
    end
    drive(2'd1, 1'b0, OP_ACK, 4'd3, 64'd0);
    #1;
    check("gap_after_sel",  64'(oup_sel),  64'd2);
    check("gap_after_last", 64'(oup_last), 64'd1);
    tick();

    // Mid-burst reset after beat 3 of 8 from input 2.
    idle_all();
    for (int b = 1; b <= 3; b++) begin
      drive(2'd2, 1'b1, OP_ACK_DATA, 4'd6, 64'(b));
      #1;
      check("mrst_sel", 64'(oup_sel), 64'd2);
      tick();
    end
    drive(2'd0, 1'b1, OP_ACK, 4'd3, 64'h10);
    drive(2'd1, 1'b1, OP_ACK, 4'd3, 64'h11);
    rst_i = 1'b1;
    #1;
    check("mrst_valid", 64'(oup_valid), 64'd0);
    check("mrst_ready", 64'(inp_ready), 64'd0);
    tick();
    rst_i = 1'b0;
    drive(2'd2, 1'b1, OP_ACK, 4'd3, 64'h12);
    #1;
    check("mrst_fresh_sel",   64'(oup_sel),   64'd0);
    check("mrst_fresh_ready", 64'(inp_ready), 64'b001);
    check("mrst_fresh_last",  64'(oup_last),  64'd1);
    tick();
    #1;
    check("mrst_next_sel", 64'(oup_sel), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_burst_arbiter_d.md
Name: tl_burst_arbiter_d

Overview:
- N-to-1 arbiter for the TileLink D channel, used in the tl_xbar response path.
- A burst is a multi-beat response: AccessAckData or GrantData.
- Once a burst has won arbitration, the grant stays locked to its source until the last beat is accepted.
- Beat count comes from d_size, d_opcode and the data-bus width. Arbitration between complete messages is round-robin, not fixed priority.

Parameters:
- SLAVE_NUM, 2, number of D-channel inputs (>=1).
- DATA_T, tl_d_chan_t, D payload struct; must contain fields opcode[2:0] and size.
- BEAT_BYTES, 8, data-bus width in bytes (power of two).
- MAX_SIZE, 6, largest legal log2(bytes) of one message; MAX_BEATS = 2^MAX_SIZE / BEAT_BYTES.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- inp_bits_i  in  SLAVE_NUM x DATA_T  per-input payload
- inp_valid_i  in  SLAVE_NUM  per-input valid
- inp_ready_o  out  SLAVE_NUM  per-input ready; one-hot or zero
- oup_bits_o  out  DATA_T  selected payload
- oup_valid_o  out  1  output valid
- oup_ready_i  in  1  downstream ready
- oup_sel_o  out  clog2(SLAVE_NUM) (min 1)  index of the granted input
- oup_last_o  out  1  current output beat is the final beat of its message

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant=0.
  - oup_valid_o=0, inp_ready_o=0, oup_sel_o=0, oup_last_o=0.
  - Reset mid-burst abandons the burst silently; no beats are replayed.
- Beat count of a message:
  - beats = (opcode==1 || opcode==5) ? max(1, 2^size / BEAT_BYTES) : 1.
  - beats saturate at MAX_BEATS when size > MAX_SIZE.
  - beat_cnt width is clog2(MAX_BEATS)+1.
- State IDLE:
  - Winner = first valid input at index >= rr_ptr, wrapping modulo SLAVE_NUM.
  - Selection is combinational: oup_valid_o = OR(inp_valid_i), zero-cycle latency.
  - oup_bits_o and oup_sel_o follow the winner. oup_last_o = (beats==1).
  - Handshake with beats==1: rr_ptr = winner+1 (wrap); stay IDLE.
  - Handshake with beats>1: beat_cnt = beats-1; grant = winner; go to BURST.
  - Valid without ready: grant = winner; go to HOLD.
- State HOLD (valid already presented, not yet accepted):
  - Output stays on grant. Other inputs are masked even if rr_ptr would prefer them; this satisfies TileLink valid/payload stability.
  - Beat count is recomputed from the held payload.
  - Handshake: same action as IDLE, using grant as the winner.
- State BURST:
  - Only the granted input is visible; all other inp_ready_o=0.
  - oup_valid_o = inp_valid_i[grant]; gaps between beats are allowed and the lock holds through them.
  - Each handshake decrements beat_cnt. oup_last_o = (beat_cnt==1).
  - Handshake at beat_cnt==1: rr_ptr = grant+1 (wrap); go to IDLE.
- Ready and payload rules:
  - inp_ready_o[i] = oup_ready_i & selected(i) & inp_valid_i[i].
  - oup_ready_i never combinationally depends on oup_valid_o.
  - Payload beats within a burst are passed through unmodified, including size and opcode.
- SLAVE_NUM==1: degenerates to a wire plus the beat counter; oup_sel_o=0.

Optional Feature:
- Macro TL_ARB_D_OUT_REG_EN.
- When defined:
  - A 2-entry skid buffer is inserted after the mux: oup_bits_o, oup_valid_o and oup_last_o are registered, adding 1 cycle of latency.
  - inp_ready_o is driven from buffer-not-full, so there is no combinational path from oup_ready_i to inp_ready_o.
  - Full throughput is kept under continuous ready.
  - The FSM advances on the mux-to-buffer handshake, not the output handshake.
  - Reset empties the buffer.
- When undefined: purely combinational datapath as described in Behaviour.

Test Plan:
- Reset: assert rst_i for 2 cycles with all inputs valid -> oup_valid_o=0 and inp_ready_o=0 during reset. First grant after release goes to input 0.
- Round-robin: SLAVE_NUM=3, BEAT_BYTES=8; all inputs continuously present AccessAck (opcode 0), ready=1 -> grant order 0,1,2,0,1,2, one per cycle, oup_last_o=1 every beat.
- Burst lock: input0 sends AccessAckData size=6 (8 beats) while input1 is valid from cycle 1 -> input1 gets no ready for 8 handshakes. oup_last_o is high on beat 8 only. Input1 is granted on the next cycle.
- Backpressure/HOLD: input1 valid and oup_ready_i=0 for 3 cycles, then input0 becomes valid with rr_ptr=0 -> oup_sel_o stays 1 and the payload is unchanged until the handshake.
- Burst gaps and saturation: GrantData size=9 with MAX_SIZE=6 and inp_valid dropping for 2 cycles mid-burst -> exactly 8 beats, lock held through the gaps, return to IDLE after the 8th.
- Mid-burst reset: rst_i asserted after beat 3 of 8 -> state IDLE, next message arbitrates fresh from rr_ptr=0.
